// File: rtl/wb_commit_stage.sv
// wb_commit_stage: WB stage - commits regfile/CSR writes, raises exceptions/interrupts and ERTN redirects.
module wb_commit_stage #(
   parameter int         CNT_W     = 32,
   parameter logic [5:0] ECODE_INT = 6'd0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ms_valid,
   output logic             ws_allowin,
   input  logic [31:0]      ms_pc,
   input  logic             ms_ex,
   input  logic [5:0]       ms_ecode,
   input  logic [8:0]       ms_esubcode,
   input  logic [31:0]      ms_vaddr,
   input  logic             ms_ertn,
   input  logic             ms_csr_re,
   input  logic             ms_csr_we,
   input  logic [13:0]      ms_csr_num,
   input  logic [31:0]      ms_csr_wmask,
   input  logic [31:0]      ms_csr_wvalue,
   input  logic             ms_rf_we,
   input  logic [4:0]       ms_rf_waddr,
   input  logic [31:0]      ms_rf_wdata,
   input  logic             has_int,
   input  logic [31:0]      csr_rvalue,
   input  logic [31:0]      ex_entry,
   input  logic [31:0]      era,
   output logic             csr_re,
   output logic             csr_we,
   output logic [13:0]      csr_num,
   output logic [31:0]      csr_wmask,
   output logic [31:0]      csr_wvalue,
   output logic             wb_ex,
   output logic [5:0]       wb_ecode,
   output logic [8:0]       wb_esubcode,
   output logic [31:0]      wb_pc,
   output logic [31:0]      wb_vaddr,
   output logic             ertn_flush,
   output logic             flush,
   output logic [31:0]      flush_target,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [31:0]      rf_wdata,
   output logic [31:0]      debug_wb_pc,
   output logic [3:0]       debug_wb_rf_we,
   output logic [4:0]       debug_wb_rf_wnum,
   output logic [31:0]      debug_wb_rf_wdata,
   output logic [CNT_W-1:0] instret
);
   logic        ws_valid, ws_ex, ws_ertn, ws_csr_re, ws_csr_we, ws_rf_we;
   logic [31:0] ws_pc, ws_vaddr, ws_csr_wmask, ws_csr_wvalue, ws_rf_wdata;
   logic [5:0]  ws_ecode;
   logic [8:0]  ws_esubcode;
   logic [13:0] ws_csr_num;
   logic [4:0]  ws_rf_waddr;
   logic        v, int_take;

   assign ws_allowin = 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         ws_valid      <= 1'b0;
         ws_pc         <= '0;
         ws_ex         <= 1'b0;
         ws_ecode      <= '0;
         ws_esubcode   <= '0;
         ws_vaddr      <= '0;
         ws_ertn       <= 1'b0;
         ws_csr_re     <= 1'b0;
         ws_csr_we     <= 1'b0;
         ws_csr_num    <= '0;
         ws_csr_wmask  <= '0;
         ws_csr_wvalue <= '0;
         ws_rf_we      <= 1'b0;
         ws_rf_waddr   <= '0;
         ws_rf_wdata   <= '0;
         instret       <= '0;
      end else begin
         ws_valid <= ms_valid & ~flush;
         if (ms_valid && ws_allowin) begin
            ws_pc         <= ms_pc;
            ws_ex         <= ms_ex;
            ws_ecode      <= ms_ecode;
            ws_esubcode   <= ms_esubcode;
            ws_vaddr      <= ms_vaddr;
            ws_ertn       <= ms_ertn;
            ws_csr_re     <= ms_csr_re;
            ws_csr_we     <= ms_csr_we;
            ws_csr_num    <= ms_csr_num;
            ws_csr_wmask  <= ms_csr_wmask;
            ws_csr_wvalue <= ms_csr_wvalue;
            ws_rf_we      <= ms_rf_we;
            ws_rf_waddr   <= ms_rf_waddr;
            ws_rf_wdata   <= ms_rf_wdata;
         end
         if (ws_valid && !wb_ex) instret <= instret + CNT_W'(1);
      end
   end

   // A reset arriving mid-commit suppresses every side effect of that commit, including the redirect.
   always_comb begin
      v                 = ws_valid & ~reset;
      int_take          = v & has_int;
      wb_ex             = int_take | (v & ws_ex);
      wb_ecode          = int_take ? ECODE_INT : ws_ecode;
      wb_esubcode       = int_take ? 9'd0 : ws_esubcode;
      wb_pc             = ws_pc;
      wb_vaddr          = ws_vaddr;
      ertn_flush        = v & ws_ertn & ~wb_ex;
      flush             = wb_ex | ertn_flush;
      flush_target      = wb_ex ? ex_entry : ertn_flush ? era : 32'd0;
      csr_we            = v & ws_csr_we & ~wb_ex;
      csr_re            = v & ws_csr_re & ~wb_ex;
      csr_num           = ws_csr_num;
      csr_wmask         = ws_csr_wmask;
      csr_wvalue        = ws_csr_wvalue;
      rf_we             = v & ws_rf_we & ~wb_ex;
      rf_waddr          = ws_rf_waddr;
      rf_wdata          = ws_csr_re ? csr_rvalue : ws_rf_wdata;
      debug_wb_pc       = ws_pc;
      debug_wb_rf_we    = {4{rf_we}};
      debug_wb_rf_wnum  = rf_waddr;
      debug_wb_rf_wdata = rf_wdata;
   end
endmodule
